jtdd_prog_sched: RTL and testbench

Programming-write scheduler between the ROM download byte stream (prog_* from the PROM/ROM write decoder) and the SDRAM controller write port. It buffers byte writes in a small FIFO, issues them as 16-bit masked writes over a req/ack handshake, and interleaves periodic refresh requests so the SDRAM stays valid during long downloads. It flags completion once the download has ended and every buffered write has retired.

---
 rtl/jtdd_prog_sched.sv | 118 +++++++++++
 tb/tb_jtdd_prog_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_prog_sched.sv
// jtdd_prog_sched: buffers ROM download bytes, issues them as masked 16-bit SDRAM writes and interleaves refresh.
// Define JTDD_PROG_MERGE_EN to merge complementary byte lanes of one address into the tail entry.
module jtdd_prog_sched #(
  parameter int FIFO_AW        = 2,
  parameter int REFRESH_CYCLES = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  output logic        prog_full,
  output logic        overflow,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic [1:0]  sdram_dqm,
  input  logic        sdram_ack,
  output logic        refresh_req,
  input  logic        refresh_ack,
  output logic        done
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(REFRESH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WRITE, REFRESH} state_t;
  state_t r_state, w_state_nx;
  logic [21:0]        r_fa [DEPTH];
  logic [15:0]        r_fd [DEPTH];
  logic [1:0]         r_fm [DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0]   r_cnt, w_cnt_nx;
  logic [TW-1:0]      r_timer;
  logic               r_pend, r_req, r_ovf, r_done;
  logic [21:0]        r_addr;
  logic [15:0]        r_din;
  logic [1:0]         r_dqm;
  logic               w_full, w_push, w_pop, w_merge, w_tz, w_rack;
  // count never exceeds DEPTH, so its MSB alone means full
  assign w_full = r_cnt[FIFO_AW];
`ifdef JTDD_PROG_MERGE_EN
  logic [FIFO_AW-1:0] w_tail;
  assign w_tail  = r_wp - 1'b1;
  assign w_merge = prog_we && r_cnt != '0 && !(r_state == WRITE && r_cnt == (FIFO_AW+1)'(1)) &&
                   prog_addr == r_fa[w_tail] && (prog_mask ^ r_fm[w_tail]) == 2'b11 && ^prog_mask;
`else
  assign w_merge = 1'b0;
`endif
  assign w_push   = prog_we && !w_full && !w_merge;
  assign w_pop    = r_state == WRITE && r_req && sdram_ack;
  assign w_tz     = r_timer == '0;
  assign w_rack   = r_state == REFRESH && refresh_ack;
  assign w_cnt_nx = r_cnt + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    w_state_nx = r_pend ? REFRESH : (r_cnt != '0 ? WRITE : IDLE);
      WRITE:   w_state_nx = w_pop ? IDLE : WRITE;
      REFRESH: w_state_nx = w_rack ? IDLE : REFRESH;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_timer <= TW'(REFRESH_CYCLES - 1);
      r_pend  <= 1'b0;
      r_req   <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dqm   <= 2'b11;
    end else begin
      r_state <= w_state_nx;
      r_wp    <= r_wp + FIFO_AW'(w_push);
      r_rp    <= r_rp + FIFO_AW'(w_pop);
      r_cnt   <= w_cnt_nx;
      r_timer <= w_tz ? TW'(REFRESH_CYCLES - 1) : r_timer - 1'b1;
      r_pend  <= w_tz | (r_pend & ~w_rack);
      r_req   <= r_state == WRITE && !w_pop;
      r_ovf   <= r_ovf | (prog_we & w_full & ~w_merge);
      r_done  <= w_state_nx == IDLE && w_cnt_nx == '0 && !downloading;
      // head is latched on the first WRITE cycle and held until the ack
      if (r_state == WRITE && !r_req) begin
        r_addr <= r_fa[r_rp];
        r_din  <= r_fd[r_rp];
        r_dqm  <= r_fm[r_rp];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wp] <= prog_addr;
      r_fd[r_wp] <= {prog_data, prog_data};
      r_fm[r_wp] <= prog_mask;
    end
`ifdef JTDD_PROG_MERGE_EN
    if (w_merge) begin
      r_fd[w_tail] <= {prog_mask[1] ? r_fd[w_tail][15:8] : prog_data,
                       prog_mask[0] ? r_fd[w_tail][7:0]  : prog_data};
      r_fm[w_tail] <= 2'b00;
    end
`endif
  end
  assign prog_full   = w_full;
  assign overflow    = r_ovf;
  assign sdram_req   = r_req;
  assign sdram_addr  = r_addr;
  assign sdram_din   = r_din;
  assign sdram_dqm   = r_dqm;
  assign refresh_req = r_state == REFRESH;
  assign done        = r_done;
endmodule

// File: tb/tb_jtdd_prog_sched.sv
// tb_jtdd_prog_sched: randomized bench for jtdd_prog_sched with a queue-based write model and
// a randomly-delayed SDRAM controller responder.
module tb_jtdd_prog_sched;
  localparam int DEPTH = 4;
  typedef struct packed {logic [21:0] a; logic [15:0] d; logic [1:0] m;} wr_t;
  logic        clk, rst, downloading, prog_we, sdram_ack, refresh_ack;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_full, overflow, sdram_req, refresh_req, done;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0]  sdram_dqm;
  int checks = 0, failures = 0;
  int m_cnt = 0, m_nref = 0;
  logic m_ovf = 0, ack_en = 0;
  logic last_ack = 0, last_rack = 0, prev_req = 0;
  logic bad_overlap = 0, bad_gap = 0, bad_stab = 0;
  logic [39:0] prev_w = '0;
  wr_t exp_q[$], got_q[$];

  jtdd_prog_sched #(.FIFO_AW(2), .REFRESH_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_mask(prog_mask), .prog_full(prog_full), .overflow(overflow),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_dqm(sdram_dqm),
    .sdram_ack(sdram_ack), .refresh_req(refresh_req), .refresh_ack(refresh_ack), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // one clock: monitor current outputs, drive inputs, update the model, wait for the next negedge
  task automatic step(input logic we, input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    logic acc, ack, rack;
    if (sdram_req === 1'b1 && refresh_req === 1'b1) bad_overlap = 1;
    if (last_ack && sdram_req !== 1'b0) bad_gap = 1;
    if (last_rack && refresh_req !== 1'b0) bad_gap = 1;
    if (prev_req && sdram_req === 1'b1 && {sdram_addr, sdram_din, sdram_dqm} !== prev_w) bad_stab = 1;
    prev_req = sdram_req === 1'b1;
    prev_w = {sdram_addr, sdram_din, sdram_dqm};
    acc = !rst && we && m_cnt < DEPTH;
    if (!rst && we && !acc) m_ovf = 1;
    if (acc) exp_q.push_back({a, {d, d}, m});
    ack = !rst && ack_en && sdram_req === 1'b1 && $urandom_range(0, 1) == 1;
    if (ack) got_q.push_back({sdram_addr, sdram_din, sdram_dqm});
    rack = !rst && refresh_req === 1'b1 && $urandom_range(0, 1) == 1;
    if (rack) m_nref++;
    m_cnt = m_cnt + int'(acc) - int'(ack);
    last_ack = ack;
    last_rack = rack;
    prog_we = we; prog_addr = a; prog_data = d; prog_mask = m;
    sdram_ack = ack; refresh_ack = rack;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 22'd0, 8'd0, 2'b11);
  endtask

  task automatic push_rand();
    step(1'b1, 22'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_reset();
    rst = 1; downloading = 0;
    idle(); idle();
    checks++; if (prog_full !== 1'b0) begin failures++; $display("FAIL rst_prog_full got=%b exp=0", prog_full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL rst_sdram_req got=%b exp=0", sdram_req); end
    checks++; if (refresh_req !== 1'b0) begin failures++; $display("FAIL rst_refresh_req got=%b exp=0", refresh_req); end
    checks++; if (sdram_addr !== 22'd0) begin failures++; $display("FAIL rst_addr got=%h exp=0", sdram_addr); end
    checks++; if (sdram_din !== 16'd0) begin failures++; $display("FAIL rst_din got=%h exp=0", sdram_din); end
    checks++; if (sdram_dqm !== 2'b11) begin failures++; $display("FAIL rst_dqm got=%b exp=11", sdram_dqm); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    rst = 0;
    idle();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL post_rst_done got=%b exp=1", done); end
  endtask

  task automatic test_single_write();
    downloading = 1; ack_en = 0;
    idle();
    step(1'b1, 22'h000123, 8'hA5, 2'b10);
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL single_req_n got=%b exp=0", sdram_req); end
    idle();
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL single_req_n1 got=%b exp=0", sdram_req); end
    idle();
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL single_req_n2 got=%b exp=1", sdram_req); end
    checks++;
    if ({sdram_addr, sdram_din, sdram_dqm} !== {22'h000123, 16'hA5A5, 2'b10}) begin
      failures++; $display("FAIL single_payload got=%h/%h/%b exp=000123/a5a5/10", sdram_addr, sdram_din, sdram_dqm);
    end
    ack_en = 1;
    for (int i = 0; i < 30 && got_q.size() < 1; i++) idle();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL single_retire got_n=%0d exp_n=1", got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    ack_en = 0;
    for (int i = 1; i <= 5; i++) begin
      push_rand();
      if (i == 3) begin
        checks++; if (prog_full !== 1'b0) begin failures++; $display("FAIL bp_full3 got=%b exp=0", prog_full); end
      end
      if (i == 4) begin
        checks++; if (prog_full !== 1'b1) begin failures++; $display("FAIL bp_full4 got=%b exp=1", prog_full); end
      end
    end
    checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL bp_overflow got=%b exp=%b", overflow, m_ovf); end
    checks++; if (prog_full !== 1'b1) begin failures++; $display("FAIL bp_full5 got=%b exp=1", prog_full); end
    ack_en = 1;
    for (int i = 0; i < 200 && got_q.size() < exp_q.size(); i++) idle();
    for (int i = 0; i < 10; i++) idle();
    checks++; if (got_q.size() != DEPTH) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), DEPTH); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_refresh();
    int nref;
    m_nref = 0;
    for (int i = 0; i < 320; i++) begin
      if ($urandom_range(0, 1) == 1) push_rand(); else idle();
    end
    nref = m_nref;
    for (int i = 0; i < 300 && (got_q.size() < exp_q.size() || m_cnt != 0); i++) idle();
    checks++; if (nref < 19 || nref > 21) begin failures++; $display("FAIL ref_count got=%0d exp=19..21", nref); end
    checks++; if (bad_overlap !== 1'b0) begin failures++; $display("FAIL ref_overlap got=%b exp=0", bad_overlap); end
    checks++; if (bad_gap !== 1'b0) begin failures++; $display("FAIL req_gap got=%b exp=0", bad_gap); end
    checks++; if (bad_stab !== 1'b0) begin failures++; $display("FAIL req_stable got=%b exp=0", bad_stab); end
    checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL ref_overflow got=%b exp=%b", overflow, m_ovf); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ref_writes got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL ref_order[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_completion();
    int pushed = 0;
    logic early = 0, reached = 0;
    downloading = 1; ack_en = 1;
    for (int i = 0; i < 2000 && pushed < 64; i++) begin
      if (m_cnt < DEPTH && $urandom_range(0, 3) != 0) begin push_rand(); pushed++; end
      else idle();
    end
    downloading = 0;
    for (int i = 0; i < 400; i++) begin
      idle();
      if (done === 1'b1 && (got_q.size() != 64 || m_cnt != 0)) early = 1;
      if (done === 1'b1) begin reached = 1; break; end
    end
    checks++; if (reached !== 1'b1) begin failures++; $display("FAIL done_timeout got=%b exp=1", done); end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", early); end
    checks++; if (got_q.size() != 64) begin failures++; $display("FAIL done_writes got=%0d exp=64", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL done_order[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    downloading = 1;
    idle();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_redownload got=%b exp=0", done); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_write();
    int first_ref = -1;
    logic seen = 0;
    downloading = 1; ack_en = 0;
    for (int i = 0; i < 3; i++) push_rand();
    for (int i = 0; i < 40 && sdram_req !== 1'b1; i++) idle();
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL rmw_req_timeout got=%b exp=1", sdram_req); end
    rst = 1;
    idle();
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL rmw_req got=%b exp=0", sdram_req); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmw_overflow got=%b exp=0", overflow); end
    checks++; if (prog_full !== 1'b0) begin failures++; $display("FAIL rmw_full got=%b exp=0", prog_full); end
    checks++; if (sdram_dqm !== 2'b11) begin failures++; $display("FAIL rmw_dqm got=%b exp=11", sdram_dqm); end
    rst = 0; downloading = 0; ack_en = 1;
    exp_q.delete(); got_q.delete(); m_cnt = 0; m_ovf = 0;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (refresh_req === 1'b1 && first_ref < 0) first_ref = i;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1; else idle();
    end
    checks++; if (first_ref != 17) begin failures++; $display("FAIL rmw_first_refresh got=%0d exp=17", first_ref); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rmw_stray_writes got=%0d exp=0", got_q.size()); end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rmw_done got=%b exp=1", done); end
  endtask

  initial begin
    rst = 1; downloading = 0; prog_we = 0; prog_addr = '0; prog_data = '0; prog_mask = 2'b11;
    sdram_ack = 0; refresh_ack = 0;
    test_reset();
    test_single_write();
    test_backpressure();
    test_refresh();
    test_completion();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
